// File: rtl/alu_decode_stage.sv
// alu_decode_stage: MIPS-style ALU decode behind a 2-entry (main + skid) valid/ready buffer.
// Optional DECODE_ILLEGAL_EN adds out_illegal, flagging encodings outside the decode table.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_aluop,
    output logic        out_asel,
    output logic        out_bsel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_pc,
    output logic        out_ovf_chk
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic        out_illegal
`endif
);

    typedef struct packed {
        logic [4:0]  aluop;
        logic        asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic        ovf_chk;
`ifdef DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } entry_t;

    entry_t      dec, main_q, main_d, skid_q, skid_d;
    logic        main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
    logic        ill, acc, drain;
    logic [5:0]  op, fn;
    logic [31:0] sext, zext;
    logic        unused_rs_rt;

    assign op   = in_instr[31:26];
    assign fn   = in_instr[5:0];
    assign sext = {{16{in_instr[15]}}, in_instr[15:0]};
    assign zext = {16'h0000, in_instr[15:0]};
    assign unused_rs_rt = ^in_instr[25:16];

    // Decoding happens on the way in, so the buffer holds ready-to-issue control words.
    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.shamt = in_instr[10:6];
        ill       = 1'b0;
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: begin dec.aluop = 5'b00000; dec.ovf_chk = 1'b1; end
                6'b100001: dec.aluop = 5'b00000;
                6'b100010,
                6'b100011: dec.aluop = 5'b00001;
                6'b100100: dec.aluop = 5'b00011;
                6'b100101: dec.aluop = 5'b00101;
                6'b100110: dec.aluop = 5'b00110;
                6'b100111: dec.aluop = 5'b00100;
                6'b101010: dec.aluop = 5'b00010;
                6'b101011: dec.aluop = 5'b01001;
                6'b000000: begin dec.aluop = 5'b00111; dec.asel = 1'b1; end
                6'b000010: begin dec.aluop = 5'b01000; dec.asel = 1'b1; end
                6'b000011: begin dec.aluop = 5'b01101; dec.asel = 1'b1; end
                6'b000100: dec.aluop = 5'b01100;
                6'b000110: dec.aluop = 5'b01110;
                6'b000111: dec.aluop = 5'b01111;
                6'b001000: dec.aluop = 5'b01011;
                6'b001001: dec.aluop = 5'b01010;
                default:   ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'b001000: begin dec.bsel = 1'b1; dec.imm = sext; dec.ovf_chk = 1'b1; end
                6'b001001,
                6'b100011,
                6'b101011: begin dec.bsel = 1'b1; dec.imm = sext; end
                6'b001010: begin dec.aluop = 5'b00010; dec.bsel = 1'b1; dec.imm = sext; end
                6'b001011: begin dec.aluop = 5'b01001; dec.bsel = 1'b1; dec.imm = sext; end
                6'b001100: begin dec.aluop = 5'b00011; dec.bsel = 1'b1; dec.imm = zext; end
                6'b001101: begin dec.aluop = 5'b00101; dec.bsel = 1'b1; dec.imm = zext; end
                6'b001110: begin dec.aluop = 5'b00110; dec.bsel = 1'b1; dec.imm = zext; end
                6'b001111: begin dec.aluop = 5'b10000; dec.bsel = 1'b1; dec.imm = zext; end
                6'b000100,
                6'b000101: begin dec.aluop = 5'b00001; dec.imm = sext; end
                default:   ill = 1'b1;
            endcase
        end
        if (ill) begin
            dec.aluop   = 5'b00000;
            dec.asel    = 1'b0;
            dec.bsel    = 1'b0;
            dec.imm     = 32'h0;
            dec.ovf_chk = 1'b0;
        end
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = ill;
`endif
    end

`ifndef DECODE_ILLEGAL_EN
    logic unused_ill;
    assign unused_ill = ill;
`endif

    // The skid entry only fills when main is held; it refills main on the next drain.
    always_comb begin
        acc      = in_valid & in_ready_q;
        drain    = main_v_q & out_ready;
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (drain) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (!main_v_q || drain) begin
            main_v_d = acc;
            main_d   = acc ? dec : main_q;
        end else if (acc) begin
            skid_v_d = 1'b1;
            skid_d   = dec;
        end
        in_ready_d = !skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_v_q;
    assign out_aluop   = main_q.aluop;
    assign out_asel    = main_q.asel;
    assign out_bsel    = main_q.bsel;
    assign out_imm     = main_q.imm;
    assign out_shamt   = main_q.shamt;
    assign out_pc      = main_q.pc;
    assign out_ovf_chk = main_q.ovf_chk;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: random + directed stimulus against a table-driven queue model of the decode stage.
module tb_alu_decode_stage;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, out_asel, out_bsel, out_ovf_chk;
    logic [4:0]  out_aluop, out_shamt;
    logic [31:0] out_imm, out_pc;
`ifdef DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
        .out_asel(out_asel), .out_bsel(out_bsel), .out_imm(out_imm),
        .out_shamt(out_shamt), .out_pc(out_pc), .out_ovf_chk(out_ovf_chk)
`ifdef DECODE_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  aluop;
        logic        asel, bsel;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic        ovf, ill;
    } exp_t;

    // {funct, aluop, asel}
    localparam logic [11:0] R_TAB [18] = '{
        {6'b100000, 5'd0, 1'b0}, {6'b100001, 5'd0, 1'b0}, {6'b100010, 5'd1, 1'b0},
        {6'b100011, 5'd1, 1'b0}, {6'b100100, 5'd3, 1'b0}, {6'b100101, 5'd5, 1'b0},
        {6'b100110, 5'd6, 1'b0}, {6'b100111, 5'd4, 1'b0}, {6'b101010, 5'd2, 1'b0},
        {6'b101011, 5'd9, 1'b0}, {6'b000000, 5'd7, 1'b1}, {6'b000010, 5'd8, 1'b1},
        {6'b000011, 5'd13, 1'b1}, {6'b000100, 5'd12, 1'b0}, {6'b000110, 5'd14, 1'b0},
        {6'b000111, 5'd15, 1'b0}, {6'b001000, 5'd11, 1'b0}, {6'b001001, 5'd10, 1'b0}
    };
    // {opcode, aluop, bsel, zero_ext}
    localparam logic [12:0] I_TAB [12] = '{
        {6'b001000, 5'd0, 1'b1, 1'b0}, {6'b001001, 5'd0, 1'b1, 1'b0},
        {6'b001010, 5'd2, 1'b1, 1'b0}, {6'b001011, 5'd9, 1'b1, 1'b0},
        {6'b001100, 5'd3, 1'b1, 1'b1}, {6'b001101, 5'd5, 1'b1, 1'b1},
        {6'b001110, 5'd6, 1'b1, 1'b1}, {6'b001111, 5'd16, 1'b1, 1'b1},
        {6'b100011, 5'd0, 1'b1, 1'b0}, {6'b101011, 5'd0, 1'b1, 1'b0},
        {6'b000100, 5'd1, 1'b0, 1'b0}, {6'b000101, 5'd1, 1'b0, 1'b0}
    };

    exp_t q[$];
    logic exp_ready = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.aluop = 0; e.asel = 0; e.bsel = 0; e.imm = 0; e.ovf = 0; e.ill = 1;
        e.shamt = ins[10:6];
        e.pc    = pc;
        if (ins[31:26] == 6'd0) begin
            for (int i = 0; i < 18; i++) begin
                logic [11:0] r = R_TAB[i];
                if (r[11:6] == ins[5:0]) begin
                    e.aluop = r[5:1]; e.asel = r[0]; e.ill = 0;
                end
            end
            e.ovf = (ins[5:0] == 6'b100000);
        end else begin
            for (int i = 0; i < 12; i++) begin
                logic [12:0] t = I_TAB[i];
                if (t[12:7] == ins[31:26]) begin
                    e.aluop = t[6:2]; e.bsel = t[1]; e.ill = 0;
                    e.imm = t[0] ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
                end
            end
            e.ovf = (ins[31:26] == 6'b001000);
        end
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, exp_ready);
        if (q.size() > 0) begin
            chk("aluop", out_aluop, q[0].aluop);
            chk("asel", out_asel, q[0].asel);
            chk("bsel", out_bsel, q[0].bsel);
            chk("imm", out_imm, q[0].imm);
            chk("shamt", out_shamt, q[0].shamt);
            chk("pc", out_pc, q[0].pc);
            chk("ovf_chk", out_ovf_chk, q[0].ovf);
`ifdef DECODE_ILLEGAL_EN
            chk("illegal", out_illegal, q[0].ill);
`endif
        end
    endtask

    task automatic model_step();
        logic acc, drn;
        if (!rst_n) begin
            q.delete();
            exp_ready = 1'b0;
        end else begin
            acc = in_valid && exp_ready;
            drn = (q.size() > 0) && out_ready;
            if (flush) q.delete();
            else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(model_dec(in_instr, in_pc));
            end
            exp_ready = q.size() < 2;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [11:0] re;
        logic [12:0] ie;
        case ($urandom_range(0, 3))
            0: begin re = R_TAB[$urandom_range(0, 17)]; r[31:26] = 6'd0; r[5:0] = re[11:6]; end
            1: begin ie = I_TAB[$urandom_range(0, 11)]; r[31:26] = ie[12:7]; end
            2: r[31:26] = 6'd0;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_aluop", out_aluop, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_ovf", out_ovf_chk, 0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 1, 0);
        chk("ready_after_reset", in_ready, 1);
        cycle(1, 32'h00221820, 32'h100, 1, 0);
        chk("add_valid", out_valid, 1);
        chk("add_aluop", out_aluop, 5'b00000);
        chk("add_asel", out_asel, 0);
        chk("add_bsel", out_bsel, 0);
        chk("add_ovf", out_ovf_chk, 1);
        cycle(1, 32'h00031100, 32'h104, 1, 0);
        chk("sll_aluop", out_aluop, 5'b00111);
        chk("sll_asel", out_asel, 1);
        chk("sll_shamt", out_shamt, 4);
        cycle(1, 32'h3C011234, 32'h108, 1, 0);
        chk("lui_aluop", out_aluop, 5'b10000);
        chk("lui_bsel", out_bsel, 1);
        chk("lui_imm", out_imm, 32'h00001234);
        cycle(1, 32'h2001FFFF, 32'h10C, 1, 0);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        cycle(1, 32'h3401FFFF, 32'h110, 1, 0);
        chk("ori_imm", out_imm, 32'h0000FFFF);
        cycle(0, 0, 0, 1, 0);
        chk("drained", out_valid, 0);
        cycle(1, 32'h00221820, 32'h200, 0, 0);
        cycle(1, 32'h00221822, 32'h204, 0, 0);
        cycle(1, 32'h00221824, 32'h208, 0, 0);
        chk("stall_ready", in_ready, 0);
        chk("stall_pc", out_pc, 32'h200);
        cycle(0, 0, 0, 0, 0);
        chk("stall_hold_pc", out_pc, 32'h200);
        chk("stall_hold_aluop", out_aluop, 5'b00000);
        cycle(0, 0, 0, 1, 0);
        chk("order_pc", out_pc, 32'h204);
        chk("order_aluop", out_aluop, 5'b00001);
        cycle(0, 0, 0, 1, 0);
        chk("no_third", out_valid, 0);
        cycle(1, 32'h00221820, 32'h300, 0, 0);
        cycle(1, 32'h00221822, 32'h304, 0, 0);
        cycle(1, 32'h00221824, 32'h308, 0, 1);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        cycle(0, 0, 0, 1, 0);
        chk("flush_nothing", out_valid, 0);
        cycle(1, 32'hFC000000, 32'h400, 1, 0);
        chk("ill_aluop", out_aluop, 0);
`ifdef DECODE_ILLEGAL_EN
        chk("ill_flag", out_illegal, 1);
`endif
        cycle(1, 32'h00221820, 32'h500, 0, 0);
        cycle(1, 32'h00221822, 32'h504, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_ready", in_ready, 0);
        chk("async_pc", out_pc, 0);
        q.delete();
        exp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1 / in_ready  out  1 / in_instr  in  32 / in_pc  in  32 (upstream fetch handshake).
REQ-004 SHALL have ports: flush  in  1  discard all held and accepted-this-cycle entries.
REQ-005 SHALL have ports: out_valid  out  1 / out_ready  in  1 (execute-stage handshake).
REQ-006 SHALL have ports: out_aluop  out  5 (ALU op code), out_asel  out  1 (0=rs, 1=shamt), out_bsel  out  1 (0=rt, 1=imm).
REQ-007 SHALL have ports: out_imm  out  32, out_shamt  out  5, out_pc  out  32, out_ovf_chk  out  1 (overflow trap enabled).

Function
REQ-008 SHALL transfer on in_valid&in_ready and on out_valid&out_ready.
REQ-009 SHALL hold a 2-entry buffer (main + skid); in_ready SHALL be a register, 1 iff skid entry empty.
REQ-010 SHALL present an accepted instruction at outputs the next cycle (latency 1) when buffer was empty.
REQ-011 SHALL keep all out_* stable while out_valid&!out_ready.
REQ-012 SHALL, on simultaneous accept and drain, keep order: oldest entry output first; no loss, no duplication.
REQ-013 SHALL, with flush=1, clear both entries and ignore in_valid that cycle; next cycle out_valid=0, in_ready=1.
REQ-014 SHALL decode opcode 000000 by funct: 100000/100001->00000, 100010/100011->00001, 100100->00011, 100101->00101, 100110->00110, 100111->00100, 101010->00010, 101011->01001.
REQ-015 SHALL decode funct shifts: 000000->00111, 000010->01000, 000011->01101 (all asel=1); 000100->01100, 000110->01110, 000111->01111 (asel=0).
REQ-016 SHALL decode funct 001000->01011 (jr), 001001->01010 (jalr).
REQ-017 SHALL decode I-type, bsel=1: 001000/001001->00000, 001010->00010, 001011->01001 (sign-ext); 001100->00011, 001101->00101, 001110->00110, 001111->10000 (zero-ext).
REQ-018 SHALL decode 100011 (lw), 101011 (sw)->00000, bsel=1, sign-ext; 000100 (beq), 000101 (bne)->00001, bsel=0.
REQ-019 SHALL set out_ovf_chk=1 only for add (funct 100000) and addi (opcode 001000).
REQ-020 SHALL drive out_shamt=instr[10:6], out_imm=ext(instr[15:0]) per class; R-type out_imm=0.
REQ-021 SHALL decode any unlisted opcode/funct to aluop 00000, asel=0, bsel=0, ovf_chk=0.

Reset
REQ-022 SHALL on rst_n=0, immediately: out_valid=0, in_ready=0, all other out_*=0, both entries empty.
REQ-023 SHALL raise in_ready on first clk edge after rst_n deasserts; reset mid-transfer drops all entries.

Configuration
REQ-024 SHALL, with DECODE_ILLEGAL_EN defined, add port out_illegal  out  1, set 1 for REQ-021 cases, 0 otherwise, reset 0.
REQ-025 SHALL, without DECODE_ILLEGAL_EN, omit out_illegal; decode otherwise identical.

Verification
REQ-026 add $3,$1,$2 (0x00221820), out_ready=1 -> next cycle out_valid=1, aluop=00000, asel=0, bsel=0, ovf_chk=1.
REQ-027 sll $2,$3,4 (0x00031100) -> aluop=00111, asel=1, shamt=4; lui $1,0x1234 (0x3C011234) -> aluop=10000, bsel=1, imm=0x00001234.
REQ-028 addi imm 0xFFFF -> imm=0xFFFFFFFF; ori imm 0xFFFF -> imm=0x0000FFFF.
REQ-029 out_ready=0, push 3 instrs -> 2 accepted, in_ready=0; release -> drained in issue order, outputs stable while stalled.
REQ-030 flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
REQ-031 opcode 0x3F with DECODE_ILLEGAL_EN -> aluop=00000, out_illegal=1; rst_n low mid-stall -> out_valid=0 asynchronously.
